// File: rtl/tetris_pkg.sv
// Shared playfield constants, scheduler state encoding and row type.
// Used by the playfield scheduler, the VGA renderer and the game logic.
package tetris_pkg;

   localparam int unsigned ROWS = 20;
   localparam int unsigned COLS = 10;
   localparam int unsigned AW   = 5;

   typedef logic [COLS-1:0] row_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RD_ISSUE,
      ST_RD_WAIT,
      ST_WR_ISSUE
   } sched_state_e;

   // True when a row index lies outside the board.
   function automatic logic row_oob(input int unsigned row, input int unsigned rows);
      return row >= rows;
   endfunction

endpackage

// File: rtl/drop_tick_gen.sv
// Drop-tick generator: counts VGA frame starts and emits a one-cycle
// game_tick_o every max(tick_div_i,1) frames.
// Ports:
//   clk_i, rst_i      clock, async active-high reset
//   frame_start_i     one-cycle pulse per VGA frame
//   tick_div_i        frames per tick, sampled at each frame start (0 acts as 1)
//   game_tick_o       registered tick pulse, one cycle after the terminal frame start
module drop_tick_gen #(
   parameter int unsigned DIVW = 6
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            frame_start_i,
   input  logic [DIVW-1:0] tick_div_i,
   output logic            game_tick_o
);

   logic [DIVW-1:0] cnt_q, cnt_d;
   logic [DIVW-1:0] lim;
   logic            tick_q, tick_d;

   assign lim = (tick_div_i == '0) ? '0 : tick_div_i - DIVW'(1);

   // Comparing with >= (not ==) makes a lowered divider tick on the next frame.
   always_comb begin
      cnt_d  = cnt_q;
      tick_d = 1'b0;
      if (frame_start_i) begin
         if (cnt_q >= lim) begin
            cnt_d  = '0;
            tick_d = 1'b1;
         end else begin
            cnt_d = cnt_q + DIVW'(1);
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   assign game_tick_o = tick_q;

endmodule

// File: rtl/playfield_access_sched.sv
// Playfield memory access scheduler: arbitrates the single-port row memory
// between renderer reads (any time, highest priority) and game writes
// (vertical blanking only), and generates the game drop tick.
// Ports:
//   clk, rst                    clock, async active-high reset
//   frame_start, vblank         VGA timing
//   rnd_req/rnd_row             renderer read request -> rnd_valid/rnd_data at N+3
//   wr_req/wr_row/wr_data       held write request -> wr_ack at N+1 (in vblank)
//   mem_en/mem_we/mem_addr/
//   mem_wdata/mem_rdata         single-port sync memory, 1-cycle read latency
//   tick_div, game_tick         drop-tick divider and pulse
//   overrun, addr_err           sticky error flags
module playfield_access_sched #(
   parameter int unsigned ROWS = tetris_pkg::ROWS,
   parameter int unsigned COLS = tetris_pkg::COLS,
   parameter int unsigned AW   = tetris_pkg::AW,
   parameter int unsigned DIVW = 6
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            frame_start,
   input  logic            vblank,
   input  logic            rnd_req,
   input  logic [AW-1:0]   rnd_row,
   output logic            rnd_valid,
   output logic [COLS-1:0] rnd_data,
   input  logic            wr_req,
   input  logic [AW-1:0]   wr_row,
   input  logic [COLS-1:0] wr_data,
   output logic            wr_ack,
   output logic            mem_en,
   output logic            mem_we,
   output logic [AW-1:0]   mem_addr,
   output logic [COLS-1:0] mem_wdata,
   input  logic [COLS-1:0] mem_rdata,
   input  logic [DIVW-1:0] tick_div,
   output logic            game_tick,
   output logic            overrun,
   output logic            addr_err
);

   import tetris_pkg::*;

   sched_state_e    state_q, state_d;
   logic            oor_q, oor_d;
   logic            rnd_valid_q, rnd_valid_d;
   logic [COLS-1:0] rnd_data_q, rnd_data_d;
   logic            wr_ack_q, wr_ack_d;
   logic            mem_en_q, mem_en_d;
   logic            mem_we_q, mem_we_d;
   logic [AW-1:0]   mem_addr_q, mem_addr_d;
   logic [COLS-1:0] mem_wdata_q, mem_wdata_d;
   logic            overrun_q, overrun_d;
   logic            addr_err_q, addr_err_d;
   logic            rd_oob, wr_oob;

   assign rd_oob = row_oob(32'(rnd_row), ROWS);
   assign wr_oob = row_oob(32'(wr_row), ROWS);

   // Memory strobes are registered, so they are computed on entry to
   // RD_ISSUE / WR_ISSUE and are visible while the FSM sits in that state.
   always_comb begin
      state_d     = state_q;
      oor_d       = oor_q;
      rnd_valid_d = 1'b0;
      rnd_data_d  = rnd_data_q;
      wr_ack_d    = 1'b0;
      mem_en_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = '0;
      mem_wdata_d = '0;
      addr_err_d  = addr_err_q;
      overrun_d   = overrun_q | (game_tick & wr_req & ~wr_ack_q);

      case (state_q)
         ST_IDLE: begin
            if (rnd_req) begin
               state_d = ST_RD_ISSUE;
               oor_d   = rd_oob;
               if (rd_oob) begin
                  addr_err_d = 1'b1;
               end else begin
                  mem_en_d   = 1'b1;
                  mem_addr_d = rnd_row;
               end
            end else if (wr_req && vblank) begin
               state_d  = ST_WR_ISSUE;
               wr_ack_d = 1'b1;
               if (wr_oob) begin
                  addr_err_d = 1'b1;
               end else begin
                  mem_en_d    = 1'b1;
                  mem_we_d    = 1'b1;
                  mem_addr_d  = wr_row;
                  mem_wdata_d = wr_data;
               end
            end
         end
         ST_RD_ISSUE: state_d = ST_RD_WAIT;
         ST_RD_WAIT: begin
            rnd_valid_d = 1'b1;
            rnd_data_d  = oor_q ? '0 : mem_rdata;
            state_d     = ST_IDLE;
         end
         ST_WR_ISSUE: state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         oor_q       <= 1'b0;
         rnd_valid_q <= 1'b0;
         rnd_data_q  <= '0;
         wr_ack_q    <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         overrun_q   <= 1'b0;
         addr_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         oor_q       <= oor_d;
         rnd_valid_q <= rnd_valid_d;
         rnd_data_q  <= rnd_data_d;
         wr_ack_q    <= wr_ack_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         overrun_q   <= overrun_d;
         addr_err_q  <= addr_err_d;
      end
   end

   drop_tick_gen #(
      .DIVW(DIVW)
   ) u_drop_tick (
      .clk_i         (clk),
      .rst_i         (rst),
      .frame_start_i (frame_start),
      .tick_div_i    (tick_div),
      .game_tick_o   (game_tick)
   );

   assign rnd_valid = rnd_valid_q;
   assign rnd_data  = rnd_data_q;
   assign wr_ack    = wr_ack_q;
   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign overrun   = overrun_q;
   assign addr_err  = addr_err_q;

endmodule

// File: tb/tb_playfield_access_sched.sv
module tb_playfield_access_sched;

   localparam int ROWS = 20;
   localparam int COLS = 10;
   localparam int AW   = 5;
   localparam int DIVW = 6;

   typedef struct {
      int              cyc;
      logic            we;
      logic [AW-1:0]   addr;
      logic [COLS-1:0] data;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst;
   logic            frame_start, vblank, rnd_req, wr_req;
   logic [AW-1:0]   rnd_row, wr_row;
   logic [COLS-1:0] wr_data;
   logic            rnd_valid, wr_ack, mem_en, mem_we, game_tick, overrun, addr_err;
   logic [COLS-1:0] rnd_data, mem_wdata;
   logic [COLS-1:0] mem_rdata = '0;
   logic [AW-1:0]   mem_addr;
   logic [DIVW-1:0] tick_div;

   logic [COLS-1:0] mem [0:(1<<AW)-1];

   exp_t rd_q[$], wr_q[$], acc_q[$], tick_q[$];
   exp_t me;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;
   int   last_rnd_cyc = -100;

   playfield_access_sched #(
      .ROWS(ROWS), .COLS(COLS), .AW(AW), .DIVW(DIVW)
   ) dut (
      .clk(clk), .rst(rst), .frame_start(frame_start), .vblank(vblank),
      .rnd_req(rnd_req), .rnd_row(rnd_row), .rnd_valid(rnd_valid), .rnd_data(rnd_data),
      .wr_req(wr_req), .wr_row(wr_row), .wr_data(wr_data), .wr_ack(wr_ack),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .tick_div(tick_div), .game_tick(game_tick),
      .overrun(overrun), .addr_err(addr_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Single-port synchronous memory model, one-cycle read latency.
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) mem[mem_addr] = mem_wdata;
         else        mem_rdata <= mem[mem_addr];
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Scoreboard: every DUT output event must match the head of its queue.
   always @(negedge clk) begin
      if (!rst) begin
         if (rd_q.size() > 0 && rd_q[0].cyc < cyc) begin
            check("rd_missing", 0, 1); void'(rd_q.pop_front());
         end
         if (wr_q.size() > 0 && wr_q[0].cyc < cyc) begin
            check("wr_missing", 0, 1); void'(wr_q.pop_front());
         end
         if (acc_q.size() > 0 && acc_q[0].cyc < cyc) begin
            check("mem_missing", 0, 1); void'(acc_q.pop_front());
         end
         if (tick_q.size() > 0 && tick_q[0].cyc < cyc) begin
            check("tick_missing", 0, 1); void'(tick_q.pop_front());
         end
         if (rnd_valid) begin
            if (rd_q.size() == 0) check("rnd_valid_unexpected", 1, 0);
            else begin
               me = rd_q.pop_front();
               check("rd_cycle", cyc, me.cyc);
               check("rd_data", 32'(rnd_data), 32'(me.data));
            end
         end
         if (wr_ack) begin
            if (wr_q.size() == 0) check("wr_ack_unexpected", 1, 0);
            else begin
               me = wr_q.pop_front();
               check("wr_cycle", cyc, me.cyc);
            end
         end
         if (game_tick) begin
            if (tick_q.size() == 0) check("tick_unexpected", 1, 0);
            else begin
               me = tick_q.pop_front();
               check("tick_cycle", cyc, me.cyc);
            end
         end
         if (mem_we && !mem_en) check("mem_we_without_en", 1, 0);
         if (mem_en) begin
            if (acc_q.size() == 0) check("mem_unexpected", 1, 0);
            else begin
               me = acc_q.pop_front();
               check("mem_cycle", cyc, me.cyc);
               check("mem_we", 32'(mem_we), 32'(me.we));
               check("mem_addr", 32'(mem_addr), 32'(me.addr));
               if (me.we) check("mem_wdata", 32'(mem_wdata), 32'(me.data));
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic rd_start(input logic [AW-1:0] row, input logic [COLS-1:0] d,
                           input bit in_range, input bit want_valid);
      exp_t e;
      check("rnd_spacing_ok", 32'(cyc - last_rnd_cyc >= 3), 1);
      last_rnd_cyc = cyc;
      e.cyc = cyc + 3; e.we = 1'b0; e.addr = row; e.data = d;
      if (want_valid) rd_q.push_back(e);
      if (in_range) begin
         e.cyc = cyc + 1;
         acc_q.push_back(e);
      end
      rnd_req = 1'b1;
      rnd_row = row;
      step();
      rnd_req = 1'b0;
   endtask

   task automatic wait_ack();
      for (int i = 0; i < 1000; i++) begin
         step();
         if (wr_ack) break;
      end
      if (!wr_ack) check("wr_ack_timeout", 0, 1);
      wr_req = 1'b0;
   endtask

   // Assumes vblank=1 and no concurrent read, so the ack lands at N+1.
   task automatic do_write(input logic [AW-1:0] row, input logic [COLS-1:0] d, input bit in_range);
      exp_t e;
      e.cyc = cyc + 1; e.we = 1'b1; e.addr = row; e.data = d;
      wr_q.push_back(e);
      if (in_range) acc_q.push_back(e);
      wr_row = row; wr_data = d; wr_req = 1'b1;
      wait_ack();
   endtask

   task automatic frame_pulse(input bit want_tick);
      exp_t e;
      e.cyc = cyc + 1; e.we = 1'b0; e.addr = '0; e.data = '0;
      if (want_tick) tick_q.push_back(e);
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      steps(3);
   endtask

   task automatic chk_zero(input string tag);
      check({tag, "_rnd_valid"}, 32'(rnd_valid), 0);
      check({tag, "_rnd_data"},  32'(rnd_data), 0);
      check({tag, "_wr_ack"},    32'(wr_ack), 0);
      check({tag, "_mem_en"},    32'(mem_en), 0);
      check({tag, "_mem_we"},    32'(mem_we), 0);
      check({tag, "_mem_addr"},  32'(mem_addr), 0);
      check({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
      check({tag, "_game_tick"}, 32'(game_tick), 0);
      check({tag, "_overrun"},   32'(overrun), 0);
      check({tag, "_addr_err"},  32'(addr_err), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      int   c;
      for (int i = 0; i < (1 << AW); i++) mem[i] = COLS'(i * 37 + 1);
      mem[3] = 10'h2A5;
      rst = 1'b1; frame_start = 1'b0; vblank = 1'b0; rnd_req = 1'b0; wr_req = 1'b0;
      rnd_row = '0; wr_row = '0; wr_data = '0; tick_div = DIVW'(3);
      steps(3);
      rst = 1'b0;
      step();
      chk_zero("reset");

      // Divider 3: ticks after frame pulses 3, 6, 9.
      for (int p = 1; p <= 9; p++) frame_pulse(p % 3 == 0);
      tick_div = '0;
      for (int p = 0; p < 3; p++) frame_pulse(1'b1);
      // Lowering the divider below the current count ticks on the next frame.
      tick_div = DIVW'(5);
      for (int p = 0; p < 3; p++) frame_pulse(1'b0);
      tick_div = DIVW'(2);
      frame_pulse(1'b1);

      // Reads during active video, including first and last rows.
      vblank = 1'b0;
      rd_start(AW'(3), 10'h2A5, 1'b1, 1'b1); steps(4);
      rd_start(AW'(0), mem[0], 1'b1, 1'b1);  steps(4);
      rd_start(AW'(19), mem[19], 1'b1, 1'b1); steps(4);

      // Write in blanking, then read it back.
      vblank = 1'b1;
      do_write(AW'(5), 10'h155, 1'b1);
      step();
      rd_start(AW'(5), 10'h155, 1'b1, 1'b1); steps(4);

      // Write deferred until blanking; vblank falls during the write cycle.
      vblank = 1'b0;
      wr_row = AW'(19); wr_data = 10'h3FF; wr_req = 1'b1;
      steps(500);
      vblank = 1'b1;
      e.cyc = cyc + 1; e.we = 1'b1; e.addr = AW'(19); e.data = 10'h3FF;
      wr_q.push_back(e); acc_q.push_back(e);
      wait_ack();
      vblank = 1'b0;
      steps(2);
      rd_start(AW'(19), 10'h3FF, 1'b1, 1'b1); steps(4);

      // Collision in blanking: read first, write three cycles later than alone.
      vblank = 1'b1;
      c = cyc;
      e.cyc = c + 3; e.we = 1'b0; e.addr = AW'(3); e.data = mem[3];
      rd_q.push_back(e);
      e.cyc = c + 1; acc_q.push_back(e);
      e.cyc = c + 4; e.we = 1'b1; e.addr = AW'(7); e.data = 10'h0C3;
      acc_q.push_back(e); wr_q.push_back(e);
      last_rnd_cyc = c;
      rnd_req = 1'b1; rnd_row = AW'(3);
      wr_req = 1'b1; wr_row = AW'(7); wr_data = 10'h0C3;
      step();
      rnd_req = 1'b0;
      wait_ack();
      steps(2);

      // Out-of-range rows.
      check("addr_err_clear", 32'(addr_err), 0);
      do_write(AW'(20), 10'h111, 1'b0);
      step();
      check("addr_err_wr", 32'(addr_err), 1);
      rst = 1'b1; step(); rst = 1'b0; step();
      check("addr_err_after_rst", 32'(addr_err), 0);
      vblank = 1'b0;
      rd_start(AW'(3), 10'h2A5, 1'b1, 1'b1); steps(4);
      rd_start(AW'(25), '0, 1'b0, 1'b1); steps(4);
      check("addr_err_rd", 32'(addr_err), 1);

      // Overrun: tick while a write is stuck outside blanking.
      tick_div = DIVW'(1);
      wr_row = AW'(2); wr_data = 10'h2AA; wr_req = 1'b1;
      step();
      check("overrun_before", 32'(overrun), 0);
      frame_pulse(1'b1);
      check("overrun_set", 32'(overrun), 1);

      // Reset during RD_WAIT aborts the read.
      rd_start(AW'(3), 10'h2A5, 1'b1, 1'b0);
      step();
      #2;
      rst = 1'b1;
      #1;
      chk_zero("midreset");
      wr_req = 1'b0;
      steps(2);
      rst = 1'b0;
      steps(10);

      check("rd_q_empty", rd_q.size(), 0);
      check("wr_q_empty", wr_q.size(), 0);
      check("acc_q_empty", acc_q.size(), 0);
      check("tick_q_empty", tick_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/playfield_access_sched.md
Name: playfield_access_sched

Overview:
- Schedules all accesses to the single-port playfield row memory (ROWS x COLS bits, one word per board row).
- The VGA renderer reads rows during active video; the game logic writes rows only during vertical blanking, so a frame never shows a half-updated board.
- Also generates the game drop tick from VGA frame starts, and flags game-logic overruns.

Parameters:
- ROWS, 20, number of board rows (memory depth)
- COLS, 10, board columns (memory word width)
- AW, 5, row address width; must satisfy 2**AW >= ROWS
- DIVW, 6, width of the drop-tick frame divider

Ports:
- clk  in  1  system clock; the only clock
- rst  in  1  asynchronous, active-high reset
- frame_start  in  1  one-cycle pulse at the start of each VGA frame (clk domain)
- vblank  in  1  high while the VGA timing is outside the visible vertical region
- rnd_req  in  1  renderer row-read request, one-cycle pulse
- rnd_row  in  AW  row to read, sampled with rnd_req
- rnd_valid  out  1  one-cycle pulse: rnd_data is valid
- rnd_data  out  COLS  row bitmap returned
- wr_req  in  1  game write request; held high until wr_ack
- wr_row  in  AW  row to write; held stable with wr_req
- wr_data  in  COLS  row bitmap to write; held stable with wr_req
- wr_ack  out  1  one-cycle pulse: write accepted
- mem_en  out  1  memory enable
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  COLS  memory write data
- mem_rdata  in  COLS  synchronous read data, valid one cycle after a read enable
- tick_div  in  DIVW  frames per drop tick; 0 is treated as 1
- game_tick  out  1  one-cycle drop-tick pulse
- overrun  out  1  sticky: a tick fired while a write was still pending
- addr_err  out  1  sticky: a request used a row >= ROWS

Behaviour:
- Reset: all outputs 0, FSM in IDLE, frame counter 0, sticky flags cleared. Reset asserted mid-transaction aborts it with no ack or valid pulse.
- All outputs are registered.
- FSM states: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE.
- IDLE, rnd_req=1 (renderer always has priority): latch rnd_row, go to RD_ISSUE.
- IDLE, rnd_req=0, wr_req=1, vblank=1: go to WR_ISSUE.
- IDLE, write requested with vblank=0: the write waits in IDLE across cycles and frames until a vblank cycle with no rnd_req.
- RD_ISSUE: drive mem_en=1, mem_we=0, mem_addr=latched row; go to RD_WAIT.
- RD_WAIT: capture mem_rdata into rnd_data, pulse rnd_valid, go to IDLE.
- Read latency: rnd_req in cycle N gives rnd_valid in cycle N+3.
- A rnd_req arriving while not in IDLE is dropped. The renderer must space requests at least 3 cycles apart; the bench checks this.
- WR_ISSUE: drive mem_en=1, mem_we=1, mem_addr=wr_row, mem_wdata=wr_data; pulse wr_ack in the same cycle; go to IDLE. wr_req seen in N gives wr_ack in N+1.
- vblank falling during WR_ISSUE: the write still completes.
- mem_en and mem_we are 0 in every other state.
- Row >= ROWS on a read: no memory access, rnd_data=0, rnd_valid still at N+3, addr_err set.
- Row >= ROWS on a write: no memory access, wr_ack still pulses, addr_err set.
- Frame counter: increments on frame_start. When count >= max(tick_div,1)-1 on a frame_start, the counter resets to 0 and game_tick pulses in the next cycle.
- tick_div is sampled at each frame_start; lowering it below the current count causes a tick on the next frame_start.
- Counter width is DIVW; it never exceeds the divider.
- overrun: set when game_tick pulses while wr_req=1 and no wr_ack is in that cycle. Cleared only by rst.

Decomposition:
- Shared package tetris_pkg: ROWS, COLS, AW, the FSM state encoding, and the playfield row type (COLS-bit vector). The VGA and game blocks use the same constants.
- Sub-module drop_tick_gen: frame counter, tick_div handling, game_tick. Arbitration FSM stays in the top.

Test Plan:
- Read during active video: vblank=0, rnd_req with rnd_row=3 in cycle 10, memory row 3 = 10'h2A5 -> mem_en=1, mem_addr=3 in cycle 11; rnd_valid=1 with rnd_data=10'h2A5 in cycle 13.
- Write deferred to blanking: wr_req with wr_row=19, wr_data=10'h3FF, vblank=0 for 500 cycles -> no wr_ack and mem_we=0 throughout; vblank rises in cycle C -> mem_we=1, mem_addr=19, wr_ack in cycle C+1.
- Collision: vblank=1, rnd_req and wr_req in the same cycle -> read issued first; wr_ack appears 3 cycles later than it would alone; memory sees exactly one read then one write.
- Out-of-range rows: read of row 25 -> rnd_data=0, rnd_valid at N+3, no mem_en, addr_err=1. Write of row 20 -> wr_ack, no mem_we.
- Tick generation: tick_div=3 over 9 frame_start pulses -> exactly 3 game_tick pulses, each one cycle after pulses 3, 6 and 9. tick_div=0 -> a tick after every frame_start.
- Reset and overrun: wr_req held with vblank=0 across a tick -> overrun=1. rst asserted mid-RD_WAIT -> all outputs 0 immediately, no rnd_valid afterwards, overrun=0.
